// File: rtl/norm_shift_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : norm_shift_pipe_if
// Description : Operand/result handshake bundle for the pipelined leading-zero
//               normaliser. The master side produces operands and consumes
//               results; the slave side is the normaliser itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface norm_shift_pipe_if #(
    parameter int W   = 24,
    parameter int SAW = 5,
    parameter int TW  = 4
);
    // Operand side
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_even;
    logic [TW-1:0]  in_tag;

    // Result side
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SAW-1:0] out_sa;
    logic           out_zero;
    logic [TW-1:0]  out_tag;

    modport master (
        output in_valid, in_data, in_even, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_sa, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_even, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_sa, out_zero, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/norm_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : norm_shift_pipe
// Description : Pipelined leading-zero normaliser. Stage k tests a shift of
//               2^(NS-k) bits; FULL mode normalises to MSB=1, EVEN mode skips
//               the final 1-bit stage so the shift total stays even.
//               Bubble-collapsing valid/ready flow control with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_shift_pipe #(
    parameter int W   = 24,
    parameter int SAW = 5,
    parameter int TW  = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    norm_shift_pipe_if.slave bus
);

    localparam int NS = SAW;

    // Stage registers, index 0 is the first stage, NS-1 drives the outputs
    logic [NS-1:0]                valid_q;
    logic [NS-1:0][W-1:0]         data_q;
    logic [NS-1:0][SAW-1:0]       sa_q;
    logic [NS-1:0]                even_q;
    logic [NS-1:0]                zero_q;
    logic [NS-1:0][TW-1:0]        tag_q;

    // What each stage sees at its input (previous stage or the operand port)
    logic [NS-1:0]                stg_valid;
    logic [NS-1:0][W-1:0]         stg_data;
    logic [NS-1:0][SAW-1:0]       stg_sa;
    logic [NS-1:0]                stg_even;
    logic [NS-1:0]                stg_zero;
    logic [NS-1:0][TW-1:0]        stg_tag;

    // Next-state values for the shifted fields
    logic [NS-1:0][W-1:0]         data_d;
    logic [NS-1:0][SAW-1:0]       sa_d;

    // A stage may load when it, or everything downstream of it, can move
    logic [NS-1:0]                ready;

    generate
        for (genvar s = 0; s < NS; s++) begin : g_stage
            localparam int             SH     = 1 << (NS - 1 - s);
            localparam logic [SAW-1:0] SA_BIT = SAW'(SH);

            logic top_zero;
            logic do_shift;

            if (s == 0) begin : g_head
                assign stg_valid[s] = bus.in_valid;
                assign stg_data[s]  = bus.in_data;
                assign stg_sa[s]    = '0;
                assign stg_even[s]  = bus.in_even;
                assign stg_zero[s]  = (bus.in_data == '0);
                assign stg_tag[s]   = bus.in_tag;
            end else begin : g_link
                assign stg_valid[s] = valid_q[s-1];
                assign stg_data[s]  = data_q[s-1];
                assign stg_sa[s]    = sa_q[s-1];
                assign stg_even[s]  = even_q[s-1];
                assign stg_zero[s]  = zero_q[s-1];
                assign stg_tag[s]   = tag_q[s-1];
            end

            // Shift when the top SH bits are clear; the 1-bit stage is
            // suppressed in EVEN mode so the total shift stays even.
            assign top_zero    = ((stg_data[s] >> (W - SH)) == '0);
            assign do_shift    = top_zero & ~(stg_even[s] & (SH == 1));
            assign data_d[s]   = do_shift ? (stg_data[s] << SH) : stg_data[s];
            assign sa_d[s]     = do_shift ? (stg_sa[s] | SA_BIT) : stg_sa[s];

            // Closed form of ready_k = ~valid_k | ready_(k+1): a stage can
            // load unless it and every stage after it is full and stalled.
            assign ready[s]    = bus.out_ready | ~(&valid_q[NS-1:s]);
        end
    endgenerate

    // Pipeline registers: flush empties every stage and wins over transfers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q <= '0;
            data_q  <= '0;
            sa_q    <= '0;
            even_q  <= '0;
            zero_q  <= '0;
            tag_q   <= '0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (flush) begin
                    valid_q[s] <= 1'b0;
                end else if (ready[s]) begin
                    valid_q[s] <= stg_valid[s];
                    if (stg_valid[s]) begin
                        data_q[s] <= data_d[s];
                        sa_q[s]   <= sa_d[s];
                        even_q[s] <= stg_even[s];
                        zero_q[s] <= stg_zero[s];
                        tag_q[s]  <= stg_tag[s];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = valid_q[NS-1];
    assign bus.out_data  = data_q[NS-1];
    assign bus.out_sa    = sa_q[NS-1];
    assign bus.out_zero  = zero_q[NS-1];
    assign bus.out_tag   = tag_q[NS-1];

endmodule
`default_nettype wire

// File: tb/tb_norm_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_norm_shift_pipe
// Description : Directed self-checking bench for norm_shift_pipe (W=24).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_shift_pipe;

    logic clk;
    logic clrn;
    logic flush;
    int   checks;
    int   errors;

    norm_shift_pipe_if #(.W(24), .SAW(5), .TW(4)) bus ();

    norm_shift_pipe #(.W(24), .SAW(5), .TW(4)) dut (
        .clk   (clk),
        .clrn  (clrn),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_even   = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
    endtask

    // Reference normaliser: plain leading-zero count
    function automatic void model(input logic [23:0] d, input logic ev,
                                  output logic [23:0] od, output logic [4:0] osa,
                                  output logic oz);
        int lz;
        if (d == 24'd0) begin
            od  = '0;
            osa = ev ? 5'd30 : 5'd31;
            oz  = 1'b1;
            return;
        end
        lz = 0;
        while (!d[23-lz]) lz++;
        if (ev) lz = lz & ~1;
        od  = d << lz;
        osa = 5'(lz);
        oz  = 1'b0;
    endfunction

    // Send one operand into an empty pipe and collect its result
    task automatic run_op(input logic ev, input logic [23:0] d, input logic [3:0] t,
                          output int lat, output logic [23:0] od, output logic [4:0] osa,
                          output logic oz, output logic [3:0] ot);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_even   = ev;
        bus.in_tag    = t;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        od  = bus.out_data;
        osa = bus.out_sa;
        oz  = bus.out_zero;
        ot  = bus.out_tag;
        tick();
    endtask

    task automatic test_reset();
        clrn  = 1'b0;
        flush = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b0;
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.out_data !== 24'd0) begin errors++; $display("FAIL reset_out_data: got %h required 000000", bus.out_data); end
        checks++; if (bus.out_sa !== 5'd0) begin errors++; $display("FAIL reset_out_sa: got %0d required 0", bus.out_sa); end
        checks++; if (bus.out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %b required 0", bus.out_zero); end
        checks++; if (bus.out_tag !== 4'd0) begin errors++; $display("FAIL reset_out_tag: got %h required 0", bus.out_tag); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        @(negedge clk);
        clrn = 1'b1;
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_full();
        logic [23:0] vd[3];
        logic [23:0] xd[3];
        logic [4:0]  xs[3];
        int lat; logic [23:0] od; logic [4:0] osa; logic oz; logic [3:0] ot;
        vd[0] = 24'h000001; xd[0] = 24'h800000; xs[0] = 5'd23;
        vd[1] = 24'h00F000; xd[1] = 24'hF00000; xs[1] = 5'd8;
        vd[2] = 24'h0000FF; xd[2] = 24'hFF0000; xs[2] = 5'd16;
        for (int k = 0; k < 3; k++) begin
            run_op(1'b0, vd[k], 4'(k + 1), lat, od, osa, oz, ot);
            checks++; if (lat !== 5) begin errors++; $display("FAIL full_latency[%0d]: got %0d required 5", k, lat); end
            checks++; if (od !== xd[k]) begin errors++; $display("FAIL full_data[%0d]: got %h required %h", k, od, xd[k]); end
            checks++; if (osa !== xs[k]) begin errors++; $display("FAIL full_sa[%0d]: got %0d required %0d", k, osa, xs[k]); end
            checks++; if (oz !== 1'b0) begin errors++; $display("FAIL full_zero[%0d]: got %b required 0", k, oz); end
            checks++; if (ot !== 4'(k + 1)) begin errors++; $display("FAIL full_tag[%0d]: got %h required %h", k, ot, 4'(k + 1)); end
        end
    endtask

    task automatic test_even();
        logic [23:0] vd[3];
        logic [23:0] xd[3];
        logic [4:0]  xs[3];
        int lat; logic [23:0] od; logic [4:0] osa; logic oz; logic [3:0] ot;
        vd[0] = 24'h000001; xd[0] = 24'h400000; xs[0] = 5'd22;
        vd[1] = 24'h008000; xd[1] = 24'h800000; xs[1] = 5'd8;
        vd[2] = 24'h004000; xd[2] = 24'h400000; xs[2] = 5'd8;
        for (int k = 0; k < 3; k++) begin
            run_op(1'b1, vd[k], 4'(k + 8), lat, od, osa, oz, ot);
            checks++; if (lat !== 5) begin errors++; $display("FAIL even_latency[%0d]: got %0d required 5", k, lat); end
            checks++; if (od !== xd[k]) begin errors++; $display("FAIL even_data[%0d]: got %h required %h", k, od, xd[k]); end
            checks++; if (osa !== xs[k]) begin errors++; $display("FAIL even_sa[%0d]: got %0d required %0d", k, osa, xs[k]); end
            checks++; if (oz !== 1'b0) begin errors++; $display("FAIL even_zero[%0d]: got %b required 0", k, oz); end
            checks++; if (ot !== 4'(k + 8)) begin errors++; $display("FAIL even_tag[%0d]: got %h required %h", k, ot, 4'(k + 8)); end
        end
    endtask

    task automatic test_boundaries();
        logic        ve[6];
        logic [23:0] vd[6];
        logic [23:0] xd[6];
        logic [4:0]  xs[6];
        logic        xz[6];
        int lat; logic [23:0] od; logic [4:0] osa; logic oz; logic [3:0] ot;
        ve[0] = 1'b0; vd[0] = 24'h800000; xd[0] = 24'h800000; xs[0] = 5'd0;  xz[0] = 1'b0;
        ve[1] = 1'b1; vd[1] = 24'h400000; xd[1] = 24'h400000; xs[1] = 5'd0;  xz[1] = 1'b0;
        ve[2] = 1'b1; vd[2] = 24'h800000; xd[2] = 24'h800000; xs[2] = 5'd0;  xz[2] = 1'b0;
        ve[3] = 1'b0; vd[3] = 24'h400000; xd[3] = 24'h800000; xs[3] = 5'd1;  xz[3] = 1'b0;
        ve[4] = 1'b0; vd[4] = 24'h000000; xd[4] = 24'h000000; xs[4] = 5'd31; xz[4] = 1'b1;
        ve[5] = 1'b1; vd[5] = 24'h000000; xd[5] = 24'h000000; xs[5] = 5'd30; xz[5] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            run_op(ve[k], vd[k], 4'(k), lat, od, osa, oz, ot);
            checks++; if (lat !== 5) begin errors++; $display("FAIL bound_latency[%0d]: got %0d required 5", k, lat); end
            checks++; if (od !== xd[k]) begin errors++; $display("FAIL bound_data[%0d]: got %h required %h", k, od, xd[k]); end
            checks++; if (osa !== xs[k]) begin errors++; $display("FAIL bound_sa[%0d]: got %0d required %0d", k, osa, xs[k]); end
            checks++; if (oz !== xz[k]) begin errors++; $display("FAIL bound_zero[%0d]: got %b required %b", k, oz, xz[k]); end
        end
    endtask

    task automatic test_mixed_modes();
        logic [23:0] vd[8];
        logic        ve[8];
        logic [23:0] xd[8];
        logic [4:0]  xs[8];
        int i, rcv;
        logic acc;
        for (int j = 0; j < 8; j++) begin
            ve[j] = (j % 2 == 0);
            if (j < 4) begin
                vd[j] = 24'h000300; xd[j] = 24'hC00000; xs[j] = 5'd14;
            end else begin
                vd[j] = 24'h000100;
                xd[j] = ve[j] ? 24'h400000 : 24'h800000;
                xs[j] = ve[j] ? 5'd14 : 5'd15;
            end
        end
        i = 0; rcv = 0;
        bus.out_ready = 1'b1;
        for (int c = 1; c <= 40 && rcv < 8; c++) begin
            if (i < 8) begin
                bus.in_valid = 1'b1; bus.in_data = vd[i]; bus.in_even = ve[i]; bus.in_tag = 4'(i);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            if (bus.out_valid) begin
                checks++; if (c !== rcv + 5) begin errors++; $display("FAIL mixed_arrival[%0d]: got edge %0d required edge %0d", rcv, c, rcv + 5); end
                checks++; if (bus.out_data !== xd[rcv]) begin errors++; $display("FAIL mixed_data[%0d]: got %h required %h", rcv, bus.out_data, xd[rcv]); end
                checks++; if (bus.out_sa !== xs[rcv]) begin errors++; $display("FAIL mixed_sa[%0d]: got %0d required %0d", rcv, bus.out_sa, xs[rcv]); end
                checks++; if (bus.out_tag !== 4'(rcv)) begin errors++; $display("FAIL mixed_tag[%0d]: got %h required %h", rcv, bus.out_tag, 4'(rcv)); end
                rcv++;
            end
        end
        checks++; if (rcv !== 8) begin errors++; $display("FAIL mixed_count: got %0d required 8", rcv); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_pressure();
        logic [23:0] vd[8];
        logic        ve[8];
        logic [23:0] xd[8];
        logic [4:0]  xs[8];
        logic        xz[8];
        logic [23:0] s_data; logic [4:0] s_sa; logic s_zero; logic [3:0] s_tag;
        int i, rcv;
        logic acc, stalled, saw_low;
        for (int k = 0; k < 8; k++) begin
            vd[k] = 24'($urandom) >> $urandom_range(0, 23);
            ve[k] = 1'($urandom_range(0, 1));
        end
        vd[6] = 24'd0;
        for (int k = 0; k < 8; k++) model(vd[k], ve[k], xd[k], xs[k], xz[k]);
        i = 0; rcv = 0; saw_low = 1'b0;
        for (int c = 0; c < 80 && rcv < 8; c++) begin
            bus.out_ready = !(c >= 3 && c <= 12);
            if (i < 8) begin
                bus.in_valid = 1'b1; bus.in_data = vd[i]; bus.in_even = ve[i]; bus.in_tag = 4'(i + 3);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                checks++; if (bus.out_tag !== 4'(rcv + 3)) begin errors++; $display("FAIL bp_tag[%0d]: got %h required %h", rcv, bus.out_tag, 4'(rcv + 3)); end
                checks++; if (bus.out_data !== xd[rcv]) begin errors++; $display("FAIL bp_data[%0d]: got %h required %h", rcv, bus.out_data, xd[rcv]); end
                checks++; if (bus.out_sa !== xs[rcv]) begin errors++; $display("FAIL bp_sa[%0d]: got %0d required %0d", rcv, bus.out_sa, xs[rcv]); end
                checks++; if (bus.out_zero !== xz[rcv]) begin errors++; $display("FAIL bp_zero[%0d]: got %b required %b", rcv, bus.out_zero, xz[rcv]); end
                rcv++;
            end
            if (!bus.in_ready && !saw_low) begin
                saw_low = 1'b1;
                checks++; if ((i - rcv) !== 5) begin errors++; $display("FAIL bp_held_at_full: got %0d held required 5", i - rcv); end
            end
            stalled = bus.out_valid && !bus.out_ready;
            s_data = bus.out_data; s_sa = bus.out_sa; s_zero = bus.out_zero; s_tag = bus.out_tag;
            @(posedge clk);
            #1;
            if (acc) i++;
            if (stalled) begin
                checks++;
                if ({bus.out_valid, bus.out_data, bus.out_sa, bus.out_zero, bus.out_tag} !== {1'b1, s_data, s_sa, s_zero, s_tag}) begin
                    errors++;
                    $display("FAIL bp_stall_stable: got %b/%h/%0d/%b/%h required 1/%h/%0d/%b/%h",
                             bus.out_valid, bus.out_data, bus.out_sa, bus.out_zero, bus.out_tag, s_data, s_sa, s_zero, s_tag);
                end
            end
        end
        checks++; if (rcv !== 8) begin errors++; $display("FAIL bp_count: got %0d required 8", rcv); end
        checks++; if (saw_low !== 1'b1) begin errors++; $display("FAIL bp_in_ready_fall: got %b required 1", saw_low); end
        idle_inputs();
        tick(); tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: got %b required 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        int lat;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_data = 24'h000010; bus.in_even = 1'b0; bus.in_tag = 4'(k + 1);
            tick();
        end
        flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 24'h000001; bus.in_tag = 4'hE;
        tick();
        flush = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b required 0", bus.out_valid); end
        bus.in_valid = 1'b1; bus.in_data = 24'h000003; bus.in_even = 1'b0; bus.in_tag = 4'h9;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL flush_latency: got %0d required 5", lat); end
        checks++; if (bus.out_tag !== 4'h9) begin errors++; $display("FAIL flush_tag: got %h required 9", bus.out_tag); end
        checks++; if (bus.out_data !== 24'hC00000) begin errors++; $display("FAIL flush_data: got %h required c00000", bus.out_data); end
        checks++; if (bus.out_sa !== 5'd22) begin errors++; $display("FAIL flush_sa: got %0d required 22", bus.out_sa); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: got %b required 0", bus.out_valid); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        int lat; logic [23:0] od; logic [4:0] osa; logic oz; logic [3:0] ot;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1; bus.in_data = 24'h000007; bus.in_even = 1'b0; bus.in_tag = 4'(k + 10);
            tick();
        end
        // mid-cycle, away from any edge
        #3;
        clrn = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.out_data !== 24'd0) begin errors++; $display("FAIL arst_out_data: got %h required 000000", bus.out_data); end
        checks++; if (bus.out_sa !== 5'd0) begin errors++; $display("FAIL arst_out_sa: got %0d required 0", bus.out_sa); end
        checks++; if (bus.out_tag !== 4'd0) begin errors++; $display("FAIL arst_out_tag: got %h required 0", bus.out_tag); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b required 1", bus.in_ready); end
        idle_inputs();
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        run_op(1'b0, 24'h000100, 4'h5, lat, od, osa, oz, ot);
        checks++; if (lat !== 5) begin errors++; $display("FAIL arst_latency: got %0d required 5", lat); end
        checks++; if (od !== 24'h800000) begin errors++; $display("FAIL arst_data: got %h required 800000", od); end
        checks++; if (osa !== 5'd15) begin errors++; $display("FAIL arst_sa: got %0d required 15", osa); end
        checks++; if (ot !== 4'h5) begin errors++; $display("FAIL arst_tag: got %h required 5", ot); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full();
        test_even();
        test_boundaries();
        test_mixed_modes();
        test_back_pressure();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
